// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: arbitration state, read-owner tag, default widths.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_H = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_C = 1'b0,
        OWNER_H = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a lock that lets the host side keep ownership across a burst.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_c,
    input  logic req_h,
    input  logic lock,
    output logic gnt_c,
    output logic gnt_h
);

    arb_state_e state_q, state_d;
    logic       locked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_c   = 1'b0;
        gnt_h   = 1'b0;
        state_d = IDLE;
        locked  = (state_q == OWN_H) && lock;

        // While locked the core is shut out even on cycles the host leaves idle.
        if (locked) begin
            gnt_h = req_h;
        end else if (req_c && req_h) begin
            if (state_q == OWN_C) begin
                gnt_h = 1'b1;
            end else begin
                gnt_c = 1'b1;
            end
        end else begin
            gnt_c = req_c;
            gnt_h = req_h;
        end

        if (gnt_c) begin
            state_d = OWN_C;
        end else if (gnt_h || locked) begin
            state_d = OWN_H;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and the host/debug port,
// steering read data back to whichever side issued the read.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   rd_pend_q, rd_pend_d;
    owner_e rd_owner_q, rd_owner_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_c (c_req),
        .req_h (h_req),
        .lock  (h_lock),
        .gnt_c (c_gnt),
        .gnt_h (h_gnt)
    );

    always_comb begin
        mem_en    = c_gnt | h_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    always_comb begin
        rd_pend_d  = mem_en & ~mem_we;
        rd_owner_d = h_gnt ? OWNER_H : OWNER_C;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWNER_C;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        c_rvalid = rd_pend_q && (rd_owner_q == OWNER_C);
        h_rvalid = rd_pend_q && (rd_owner_q == OWNER_H);
        c_rdata  = c_rvalid ? mem_rdata : '0;
        h_rdata  = h_rvalid ? mem_rdata : '0;
    end

    a_one_grant : assert property (@(posedge clk) disable iff (!reset) !(c_gnt && h_gnt));
    a_c_held    : assert property (@(posedge clk) disable iff (!reset) c_req && !c_gnt |=> c_req);
    a_h_held    : assert property (@(posedge clk) disable iff (!reset) h_req && !h_gnt |=> h_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model behind the mem_* port.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          h_req, h_we, h_lock, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:63];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_lock    (h_lock),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
    endtask

    task automatic drive_h(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic lock);
        h_req = req; h_we = we; h_addr = addr; h_wdata = wdata; h_lock = lock;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;
        mem[16] = 32'h1111_C0DE;
        mem[32] = 32'h2222_40DE;

        reset = 1'b0;
        drive_c(1'b0, 1'b0, '0, '0);
        drive_h(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset: everything quiet for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_ctl", {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_en, mem_we}, 64'h0);
            check_eq("idle_data", {mem_addr, mem_wdata} | {c_rdata, h_rdata}, 64'h0);
        end
        step();

        // Single core read of 0x10.
        drive_c(1'b1, 1'b0, 32'h10, '0);
        @(negedge clk);
        check_eq("cr_gnt", {c_gnt, h_gnt, mem_en, mem_we}, 64'b1010);
        check_eq("cr_addr", mem_addr, 64'h10);
        step();
        drive_c(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("cr_rvalid", {c_rvalid, h_rvalid}, 64'b10);
        check_eq("cr_rdata", c_rdata, 64'hDEAD_BEEF);
        check_eq("cr_hdata", h_rdata, 64'h0);
        step();

        // Both read every cycle from IDLE: C, H, C, H, then the still-waiting core.
        drive_c(1'b1, 1'b0, 32'h40, '0);
        drive_h(1'b1, 1'b0, 32'h80, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) check_eq("rr_gnt", {c_gnt, h_gnt, mem_addr}, {2'b10, 32'h40});
            else            check_eq("rr_gnt", {c_gnt, h_gnt, mem_addr}, {2'b01, 32'h80});
            if (i % 2 == 1) check_eq("rr_rsp", {c_rvalid, h_rvalid, c_rdata}, {2'b10, 32'h1111_C0DE});
            if (i == 2)     check_eq("rr_rsp", {c_rvalid, h_rvalid, h_rdata}, {2'b01, 32'h2222_40DE});
            step();
        end
        drive_h(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check_eq("rr_last_gnt", {c_gnt, h_gnt}, 64'b10);
        check_eq("rr_last_rsp", {c_rvalid, h_rvalid, h_rdata}, {2'b01, 32'h2222_40DE});
        step();
        drive_c(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("rr_tail_rsp", {c_rvalid, h_rvalid, c_rdata}, {2'b10, 32'h1111_C0DE});
        step();

        // Locked host write burst while the core waits.
        for (int i = 0; i < 4; i++) begin
            drive_h(1'b1, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
            if (i > 0) drive_c(1'b1, 1'b0, 32'h10, '0);
            @(negedge clk);
            check_eq("lk_gnt", {c_gnt, h_gnt, mem_we, h_rvalid}, 64'b0110);
            check_eq("lk_addr", {mem_addr, mem_wdata}, {32'(4 * i), 32'hA0 + 32'(i)});
            step();
        end
        drive_h(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check_eq("lk_release", {c_gnt, h_gnt, mem_addr}, {2'b10, 32'h10});
        step();
        drive_c(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("lk_rdata", {c_rvalid, c_rdata}, {1'b1, 32'hDEAD_BEEF});
        check_eq("lk_mem", mem[2], 64'hA2);
        step();

        // Host write then core read of the same word.
        drive_h(1'b1, 1'b1, 32'h20, 32'h55AA, 1'b0);
        @(negedge clk);
        check_eq("wr_gnt", {c_gnt, h_gnt, mem_we, mem_wdata}, {3'b011, 32'h55AA});
        step();
        drive_h(1'b0, 1'b0, '0, '0, 1'b0);
        drive_c(1'b1, 1'b0, 32'h20, '0);
        @(negedge clk);
        check_eq("wr_nornd", {c_gnt, h_rvalid, c_rvalid}, 64'b100);
        step();
        drive_c(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("wr_rdata", {c_rvalid, c_rdata}, {1'b1, 32'h55AA});
        step();

        // Async reset in the cycle after a granted read drops the response.
        drive_c(1'b1, 1'b0, 32'h10, '0);
        @(negedge clk);
        check_eq("rst_gnt", c_gnt, 64'h1);
        step();
        drive_c(1'b0, 1'b0, '0, '0);
        check_eq("rst_pre", c_rvalid, 64'h1);
        reset = 1'b0;
        #1;
        check_eq("rst_async", {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_en, c_rdata}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_after", {c_rvalid, h_rvalid, c_rdata, h_rdata}, 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the RISC-V core's load/store path and a host/debug port used for program loading and memory inspection. It sits between the core's data-memory interface and the memory macro. It grants one access per cycle with round-robin fairness and an optional host lock for bursts. It routes read data back to the issuing requester one cycle later.

## Interface
- ADDR_W, 32, byte address width of both requesters and memory
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request; held with its fields stable until granted
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core access accepted this cycle; core stalls while c_req & !c_gnt
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- h_req, h_we, h_addr, h_wdata  in  1/1/ADDR_W/DATA_W  host request, same meaning as core
- h_lock  in  1  host holds ownership across consecutive cycles (burst)
- h_gnt, h_rvalid, h_rdata  out  1/1/DATA_W  host grant / read valid / read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1

## Operation
- FSM state register: IDLE, OWN_C, OWN_H. The state records the last owner or the lock holder. Reset state is IDLE.
- Grant is combinational from the request inputs and the state register:
  - Only one requester active: that requester is granted.
  - Both active, state IDLE or OWN_H without lock: core granted.
  - Both active, state OWN_C: host granted (round robin).
  - State OWN_H with h_lock=1: host granted whenever h_req=1. The core is refused even if the host is idle that cycle.
- State update at each clock edge:
  - c_gnt → OWN_C.
  - h_gnt → OWN_H.
  - No grant and not locked → IDLE.
  - OWN_H with h_lock=1 stays in OWN_H.
  - Lock released (h_lock=0) → normal arbitration resumes next cycle.
- Memory mux: mem_en = c_gnt | h_gnt. mem_we, mem_addr and mem_wdata come from the granted requester. All are zero when no grant.
- Read return:
  - rd_pend and rd_owner are registered on any granted read.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata.
  - The other requester's rdata is forced to 0 and its rvalid to 0.
- Writes produce no rvalid.
- At most one grant per cycle; c_gnt & h_gnt is never 1.

## Timing
- Reset values: all gnt, rvalid, mem_* outputs = 0; rdata = 0; state IDLE; rd_pend 0.
- Grant latency: 0 cycles, same cycle as the request when arbitration is won.
- Read latency: 1 cycle from grant to rvalid. Back-to-back reads give rvalid every cycle.
- Starvation bound: with both requesting and no lock, each requester waits at most 1 cycle.
- With h_lock held, the core waits for the lock duration plus 1 cycle.
- Reset asserted mid-read: the pending read is dropped and rvalid stays 0 after reset release.
- Request withdrawn before grant is a protocol violation. Behaviour is undefined; assertion only.

## Structure
- Shared package dmem_pkg: state enum (IDLE, OWN_C, OWN_H), owner encoding (OWNER_C=0, OWNER_H=1), default widths.
- Optional sub-module rr_arb2: the 2-way round-robin grant logic with a lock input, reusable for the instruction-memory load path.

## Test plan
- Reset release, no requests → all outputs 0, state IDLE for 5 cycles.
- Core read addr 0x10, mem_rdata=0xDEADBEEF → c_gnt same cycle, mem_addr=0x10, next cycle c_rvalid=1, c_rdata=0xDEADBEEF, h_rvalid=0.
- Both request every cycle from IDLE → grants alternate C, H, C, H. Read data is steered to the correct requester each cycle.
- Host write burst of 4 to 0x0/0x4/0x8/0xC with h_lock=1 while the core requests → 4 host grants, then c_gnt on the cycle after lock drops.
- Host write 0x55AA at 0x20 while the core reads 0x20 next → core reads 0x55AA one cycle after its grant.
- Reset pulsed low in the cycle after a granted read → no rvalid; outputs return to reset values immediately (asynchronous).
